// File: rtl/ps2_pkg.sv
// Shared PS/2 receive constants: FSM encoding, prefix codes, frame check.
package ps2_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DATA   = 3'd1;
  localparam logic [2:0] ST_PARITY = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
  localparam logic [2:0] ST_CHECK  = 3'd4;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;

  // Odd parity over data+parity and a high stop bit make a good frame.
  function automatic logic frame_ok(input logic [7:0] d, input logic p, input logic s);
    return (^{d, p}) & s;
  endfunction

endpackage

// File: rtl/ps2_rx_frame_ctrl_if.sv
// PS/2 pin inputs and decoded scancode outputs of the receive controller.
interface ps2_rx_frame_ctrl_if;
  logic       PS2_CLK_Pin_In;
  logic       PS2_DAT_Pin_In;
  logic [7:0] Rx_Data;
  logic       Rx_Done_Sig;
  logic       Break_Sig;
  logic       Ext_Sig;
  logic       Err_Sig;

  modport master (
    output PS2_CLK_Pin_In, PS2_DAT_Pin_In,
    input  Rx_Data, Rx_Done_Sig, Break_Sig, Ext_Sig, Err_Sig
  );

  modport slave (
    input  PS2_CLK_Pin_In, PS2_DAT_Pin_In,
    output Rx_Data, Rx_Done_Sig, Break_Sig, Ext_Sig, Err_Sig
  );
endinterface

// File: rtl/ps2_clk_fall_detect.sv
// Two-flop synchronizer plus one history flop; one pulse per falling edge.
module ps2_clk_fall_detect (
  input  logic CLK,
  input  logic RSTn,
  input  logic pin,
  output logic fall
);
  // sync[0..1] synchronize, sync[2] is the previous synced value.
  // Reset to all ones so an idle-high pin never looks like an edge.
  logic [2:0] sync;

  // Shift the pin through the synchronizer and history flop.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) sync <= 3'b111;
    else       sync <= {sync[1:0], pin};
  end

  assign fall = sync[2] & ~sync[1];
endmodule

// File: rtl/ps2_rx_frame_ctrl.sv
// PS/2 device-to-host frame receiver with break/extend prefix tracking.
module ps2_rx_frame_ctrl
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 100000
) (
  input logic                CLK,
  input logic                RSTn,
  ps2_rx_frame_ctrl_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic          fall;
  logic [1:0]    dat_sync;
  logic          dat;
  logic [2:0]    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic          stop_bit;
  logic [CW-1:0] to_cnt;
  logic          brk_p;
  logic          ext_p;
  logic          in_frame;
  logic          timeout;
  logic [7:0]    rx_data;
  logic          rx_done;
  logic          brk_o;
  logic          ext_o;
  logic          err_o;

  ps2_clk_fall_detect u_clk_fall (
    .CLK  (CLK),
    .RSTn (RSTn),
    .pin  (bus.PS2_CLK_Pin_In),
    .fall (fall)
  );

  // Plain two-flop synchronizer for the data pin.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) dat_sync <= 2'b11;
    else       dat_sync <= {dat_sync[0], bus.PS2_DAT_Pin_In};
  end
  assign dat = dat_sync[1];

  // An edge always beats the idle limit in the same cycle.
  assign in_frame = (state == ST_DATA) || (state == ST_PARITY) || (state == ST_STOP);
  assign timeout  = in_frame && !fall && (to_cnt == CW'(TIMEOUT_CYC - 1));

  // Idle counter: runs only mid-frame between clock edges.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)                    to_cnt <= '0;
    else if (fall || !in_frame)   to_cnt <= '0;
    else if (timeout)             to_cnt <= '0;
    else                          to_cnt <= to_cnt + 1'b1;
  end

  // Frame FSM, prefix flags and registered outputs.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      stop_bit <= 1'b0;
      brk_p    <= 1'b0;
      ext_p    <= 1'b0;
      rx_data  <= '0;
      rx_done  <= 1'b0;
      brk_o    <= 1'b0;
      ext_o    <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      err_o   <= 1'b0;
      case (state)
        ST_IDLE: if (fall && !dat) begin
          state   <= ST_DATA;
          bit_cnt <= '0;
        end
        ST_DATA: if (fall) begin
          shreg   <= {dat, shreg[7:1]};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) state <= ST_PARITY;
        end
        ST_PARITY: if (fall) begin
          par_bit <= dat;
          state   <= ST_STOP;
        end
        ST_STOP: if (fall) begin
          stop_bit <= dat;
          state    <= ST_CHECK;
        end
        ST_CHECK: begin
          state <= ST_IDLE;
          if (frame_ok(shreg, par_bit, stop_bit)) begin
            if (shreg == BREAK_CODE)    brk_p <= 1'b1;
            else if (shreg == EXT_CODE) ext_p <= 1'b1;
            else begin
              rx_data <= shreg;
              brk_o   <= brk_p;
              ext_o   <= ext_p;
              rx_done <= 1'b1;
              brk_p   <= 1'b0;
              ext_p   <= 1'b0;
            end
          end else begin
            err_o <= 1'b1;
            brk_p <= 1'b0;
            ext_p <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (timeout) begin
        state <= ST_IDLE;
        err_o <= 1'b1;
        brk_p <= 1'b0;
        ext_p <= 1'b0;
      end
    end
  end

  assign bus.Rx_Data     = rx_data;
  assign bus.Rx_Done_Sig = rx_done;
  assign bus.Break_Sig   = brk_o;
  assign bus.Ext_Sig     = ext_o;
  assign bus.Err_Sig     = err_o;
endmodule

// File: tb/tb_ps2_rx_frame_ctrl.sv
// Directed bench for ps2_rx_frame_ctrl with an expected-event queue.
module tb_ps2_rx_frame_ctrl;
  localparam int TO = 200;

  logic CLK = 1'b0;
  logic RSTn;
  ps2_rx_frame_ctrl_if bus ();

  ps2_rx_frame_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit         err;
    logic [7:0] data;
    logic       brk;
    logic       ext;
    bit         lat;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   stop_cyc = 0;

  always @(posedge CLK) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic exp_done(input logic [7:0] d, input logic b, input logic x);
    q.push_back('{err: 1'b0, data: d, brk: b, ext: x, lat: 1'b1});
  endtask

  // Outputs held at the values given while Err_Sig pulses.
  task automatic exp_err(input logic [7:0] d, input logic b, input logic x, input bit lat);
    q.push_back('{err: 1'b1, data: d, brk: b, ext: x, lat: lat});
  endtask

  task automatic ps2_bit(input logic b, input bit is_stop);
    @(negedge CLK);
    bus.PS2_DAT_Pin_In = b;
    repeat (5) @(negedge CLK);
    bus.PS2_CLK_Pin_In = 1'b0;
    if (is_stop) stop_cyc = cyc;
    repeat (10) @(negedge CLK);
    bus.PS2_CLK_Pin_In = 1'b1;
    repeat (5) @(negedge CLK);
  endtask

  task automatic send(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i], 1'b0);
    ps2_bit((~^d) ^ bad_par, 1'b0);
    ps2_bit(~bad_stop, 1'b1);
    repeat (10) @(negedge CLK);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_rx_data"}, bus.Rx_Data, 8'h00);
    chk({tag, "_done"},    bus.Rx_Done_Sig, 1'b0);
    chk({tag, "_break"},   bus.Break_Sig, 1'b0);
    chk({tag, "_ext"},     bus.Ext_Sig, 1'b0);
    chk({tag, "_err"},     bus.Err_Sig, 1'b0);
  endtask

  // Scoreboard: every Rx_Done_Sig/Err_Sig pulse must match the queue head.
  always @(negedge CLK) begin
    if (RSTn === 1'b1 && (bus.Rx_Done_Sig || bus.Err_Sig)) begin
      chk("done_err_exclusive", bus.Rx_Done_Sig & bus.Err_Sig, 1'b0);
      if (q.size() == 0) begin
        chk("unexpected_pulse", {bus.Rx_Done_Sig, bus.Err_Sig}, 2'b00);
      end else begin
        e = q.pop_front();
        chk("pulse_kind", bus.Err_Sig, e.err);
        chk("rx_data",    bus.Rx_Data, e.data);
        chk("break_sig",  bus.Break_Sig, e.brk);
        chk("ext_sig",    bus.Ext_Sig, e.ext);
        if (e.lat) chk("latency", cyc - stop_cyc, 4);
      end
    end
  end

  initial begin
    bus.PS2_CLK_Pin_In = 1'b1;
    bus.PS2_DAT_Pin_In = 1'b1;
    RSTn = 1'b0;
    repeat (5) @(negedge CLK);
    chk_quiet("reset");
    RSTn = 1'b1;
    repeat (5) @(negedge CLK);

    // Stray edge with data high in IDLE: ignored, no error.
    ps2_bit(1'b1, 1'b0);

    // Plain make code.
    exp_done(8'h1C, 1'b0, 1'b0);
    send(8'h1C, 1'b0, 1'b0);

    // Break prefix.
    send(8'hF0, 1'b0, 1'b0);
    exp_done(8'h1C, 1'b1, 1'b0);
    send(8'h1C, 1'b0, 1'b0);

    // Extended break, then plain code clears both flags.
    send(8'hE0, 1'b0, 1'b0);
    send(8'hF0, 1'b0, 1'b0);
    exp_done(8'h75, 1'b1, 1'b1);
    send(8'h75, 1'b0, 1'b0);
    exp_done(8'h1C, 1'b0, 1'b0);
    send(8'h1C, 1'b0, 1'b0);
    repeat (30) @(negedge CLK);
    chk("rx_data_held", bus.Rx_Data, 8'h1C);

    // Parity error after a break prefix: data held, prefix dropped.
    exp_done(8'h29, 1'b0, 1'b0);
    send(8'h29, 1'b0, 1'b0);
    send(8'hF0, 1'b0, 1'b0);
    exp_err(8'h29, 1'b0, 1'b0, 1'b1);
    send(8'h1C, 1'b1, 1'b0);
    exp_done(8'h1C, 1'b0, 1'b0);
    send(8'h1C, 1'b0, 1'b0);

    // Stop-bit error.
    exp_err(8'h1C, 1'b0, 1'b0, 1'b1);
    send(8'h5A, 1'b0, 1'b1);

    // Timeout: start + 4 data bits, then clock idles high.
    exp_err(8'h1C, 1'b0, 1'b0, 1'b0);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1, 1'b0);
    repeat (TO + 50) @(negedge CLK);
    chk("timeout_seen", q.size(), 0);
    exp_done(8'h1C, 1'b0, 1'b0);
    send(8'h1C, 1'b0, 1'b0);

    // Reset mid-frame with a break pending.
    send(8'hF0, 1'b0, 1'b0);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1, 1'b0);
    RSTn = 1'b0;
    repeat (3) @(negedge CLK);
    chk_quiet("midframe_reset");
    RSTn = 1'b1;
    repeat (5) @(negedge CLK);
    exp_done(8'h1C, 1'b0, 1'b0);
    send(8'h1C, 1'b0, 1'b0);

    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge CLK);
    chk("queue_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
